// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// This package holds the state encoding and the default operand width.
package serial_arith_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int         W_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;
endpackage

// File: rtl/halfadder_strl.sv
// Structural 1-bit half adder.
module halfadder_strl (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl_fa.sv
// 1-bit full adder built from two half adders and an OR of their carries.
module fa_slice_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;

  halfadder_strl u_ha0 (.a(a),  .b(b),   .s(s0),  .c(c0));
  halfadder_strl u_ha1 (.a(s0), .b(cin), .s(sum), .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: one full-adder slice reused LSB-first across W cycles,
// with valid/ready handshakes on both the operand side and the result side.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum_out,
  output logic         busy
);
  localparam int              CW       = $clog2(W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_sh_q, res_sh_d;
  logic          carry_q, carry_d;
  logic [W:0]    sum_q, sum_d;
  logic          fa_sum, fa_cout;

  fa_slice_ha u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        res_sh_d = {fa_sum, res_sh_q[W-1:1]};
        // Hold cnt on the last bit so it never wraps when W is a power of two.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_cout, res_sh_d};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum_out   = sum_q;
endmodule
